// File: rtl/instr_fetch_unit.sv
// Purpose : Beta front end. Owns the PC, picks the next PC, runs the imem req/ack
//           handshake and presents the fetched word and its PC to the IR.
// Latency : 1 cycle from an accepted ack to InstrValid. Stall holds DONE; redirects never stall.
//
// Ports:
//   Clock, Reset            rising-edge clock, async active-low reset
//   Stall                   hold PC and presented instruction while in DONE
//   BranchTaken/Target      taken branch; the target keeps the current supervisor bit
//   JumpTaken/Target        JMP; the supervisor bit can only be cleared, never set
//   IllOp, IntReq           exception sources (IntReq is honoured in user mode only)
//   ImemReq/Addr/Ack/Rdata  single-outstanding instruction memory handshake
//   InstrOut/Valid, PcOut   fetched word and its PC, to the IR
//   FetchBusy               state != DONE, feeds IR stall
//   Redirect, ExcTaken      1-cycle pulses, feed IR Flush / ExcAck
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [31:0] XADR_VECTOR  = 32'h8000_0008
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    input  logic        IllOp,
    input  logic        IntReq,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrOut,
    output logic        InstrValid,
    output logic [31:0] PcOut,
    output logic        FetchBusy,
    output logic        Redirect,
    output logic        ExcTaken
);

    typedef enum logic [1:0] {FETCH, DONE, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, redir_pc, next_seq;
    logic        int_ok, redir, exc, capture;

    // Bits the PC datapath never looks at: word offsets and the branch target's
    // mode bit (a branch cannot change mode).
    logic unused_bits;
    assign unused_bits = ^{BranchTarget[31], BranchTarget[1:0], JumpTarget[1:0]};

    assign ImemAddr = {pc[31:2], 2'b00};

    always_comb begin
        int_ok   = IntReq && !pc[31];
        exc      = IllOp || int_ok;
        redir    = exc || JumpTaken || BranchTaken;
        next_seq = {pc[31], pc[30:0] + 31'd4};

        if (IllOp)
            redir_pc = ILLOP_VECTOR;
        else if (int_ok)
            redir_pc = XADR_VECTOR;
        else if (JumpTaken)
            redir_pc = {pc[31] & JumpTarget[31], JumpTarget[30:2], 2'b00};
        else
            redir_pc = {pc[31], BranchTarget[30:2], 2'b00};

        // An ack only counts while a request is actually on the bus; the cycle
        // straight out of reset has ImemReq=0, so an ack left over from before
        // reset falls on the floor.
        capture   = (state == FETCH) && ImemReq && ImemAck && !redir;
        state_nxt = state;
        pc_nxt    = pc;

        case (state)
            FETCH: begin
                if (redir) begin
                    pc_nxt = redir_pc;
                    // Request in flight and unanswered: its answer is stale, so
                    // swallow it before issuing the new address.
                    state_nxt = (ImemReq && !ImemAck) ? DISCARD : FETCH;
                end else if (capture) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (redir) begin
                    pc_nxt    = redir_pc;
                    state_nxt = FETCH;
                end else if (!Stall) begin
                    pc_nxt    = next_seq;
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (redir)
                    pc_nxt = redir_pc;
                // The stale ack retires the old request even if a redirect lands
                // in the same cycle; waiting for a second ack would hang.
                if (ImemAck)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= FETCH;
            pc         <= RESET_VECTOR;
            ImemReq    <= 1'b0;
            InstrOut   <= '0;
            PcOut      <= '0;
            InstrValid <= 1'b0;
            FetchBusy  <= 1'b1;
            Redirect   <= 1'b0;
            ExcTaken   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ImemReq    <= (state_nxt == FETCH);
            FetchBusy  <= (state_nxt != DONE);
            InstrValid <= (state_nxt == DONE);
            Redirect   <= redir;
            ExcTaken   <= exc;
            if (capture) begin
                InstrOut <= ImemRdata;
                PcOut    <= pc;
            end
        end
    end

endmodule
